// File: rtl/ioctl_stream_gen.sv
// ioctl_stream_gen: plays one MiSTer ioctl download segment per start, pulling words from a valid/ready source.
// Pre/post gaps and write-slot pacing are frozen cycle-for-cycle by i_IOCTL_WAIT.
module ioctl_stream_gen #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 27,
   parameter int LEN_W    = 24,
   parameter int INTERVAL = 6,
   parameter int PRE_GAP  = 192,
   parameter int POST_GAP = 128
) (
   input  logic              i_HPSIO_CLK,
   input  logic              i_RST,
   input  logic              i_START,
   input  logic [15:0]       i_INDEX,
   input  logic [LEN_W-1:0]  i_LEN,
   output logic              o_BUSY,
   output logic              o_DONE,
   input  logic [DATA_W-1:0] i_SRC_DATA,
   input  logic              i_SRC_VALID,
   output logic              o_SRC_READY,
   output logic              o_IOCTL_DOWNLOAD,
   output logic [15:0]       o_IOCTL_INDEX,
   output logic [ADDR_W-1:0] o_IOCTL_ADDR,
   output logic [DATA_W-1:0] o_IOCTL_DATA,
   output logic              o_IOCTL_WR,
   input  logic              i_IOCTL_WAIT
);
   localparam int STEP  = DATA_W / 8;
   localparam int GAP_N = (PRE_GAP > POST_GAP) ? PRE_GAP : POST_GAP;
   localparam int GAP_W = $clog2(GAP_N + 1);
   localparam int C_W   = $clog2(INTERVAL);

   typedef enum logic [2:0] {IDLE, PRE, FETCH, SLOT, POST} state_t;
   state_t r_state, w_next;
   logic [GAP_W-1:0]  r_gap;
   logic [C_W-1:0]    r_c;
   logic [LEN_W-1:0]  r_len;
   logic [15:0]       r_index;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic              r_busy, r_done, r_dl, r_wr;
   logic              w_go, w_gap_last, w_slot_last, w_hs, w_ready;

   assign w_go        = ~i_IOCTL_WAIT;
   assign w_gap_last  = (r_state == PRE) ? (r_gap == GAP_W'(PRE_GAP - 1)) : (r_gap == GAP_W'(POST_GAP - 1));
   assign w_slot_last = (r_c == C_W'(INTERVAL - 1));
   assign w_hs        = w_ready & i_SRC_VALID;

   always_ff @(posedge i_HPSIO_CLK or posedge i_RST)
      if (i_RST) r_state <= IDLE;
      else r_state <= w_next;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = i_START ? PRE : IDLE;
         PRE:     if (w_go && w_gap_last) w_next = (r_len == '0) ? POST : FETCH;
         FETCH:   if (w_hs) w_next = SLOT;
         SLOT:    if (w_go && w_slot_last) w_next = (r_len == LEN_W'(1)) ? POST : FETCH;
         POST:    if (w_go && w_gap_last) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // The source handshake is the only combinational output.
   always_comb w_ready = (r_state == FETCH) & w_go;

   always_ff @(posedge i_HPSIO_CLK or posedge i_RST)
      if (i_RST) begin
         r_gap   <= '0;
         r_c     <= '0;
         r_len   <= '0;
         r_index <= '0;
         r_addr  <= '0;
         r_data  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_dl    <= 1'b0;
         r_wr    <= 1'b0;
      end else begin
         r_wr   <= (r_state == SLOT) && w_go && (r_c == '0);
         r_done <= (r_state == POST) && w_go && w_gap_last;
         if (r_state == IDLE && i_START) begin
            r_index <= i_INDEX;
            r_len   <= i_LEN;
            r_addr  <= '0;
            r_busy  <= 1'b1;
            r_dl    <= 1'b1;
         end
         if ((r_state == PRE || r_state == POST) && w_go) r_gap <= w_gap_last ? '0 : r_gap + GAP_W'(1);
         if (w_hs) begin
            r_data <= i_SRC_DATA;
            r_c    <= '0;
         end
         if (r_state == SLOT && w_go) begin
            r_c <= r_c + C_W'(1);
            if (w_slot_last) begin
               r_addr <= r_addr + ADDR_W'(STEP);
               r_len  <= r_len - LEN_W'(1);
            end
         end
         if (w_next == POST && r_state != POST) r_dl <= 1'b0;
         if (r_state == POST && w_next == IDLE) r_busy <= 1'b0;
      end

   assign o_BUSY           = r_busy;
   assign o_DONE           = r_done;
   assign o_SRC_READY      = w_ready;
   assign o_IOCTL_DOWNLOAD = r_dl;
   assign o_IOCTL_INDEX    = r_index;
   assign o_IOCTL_ADDR     = r_addr;
   assign o_IOCTL_DATA     = r_data;
   assign o_IOCTL_WR       = r_wr;
endmodule

// File: tb/tb_ioctl_stream_gen.sv
// tb_ioctl_stream_gen: 8- and 16-bit instances driven in lockstep; expected writes and DONEs
// are queued by the stimulus and consumed by per-instance monitors on the falling edge.
module tb_ioctl_stream_gen;
   typedef struct packed {
      logic [26:0] a;
      logic [15:0] d;
      logic [15:0] i;
   } wr_t;

   logic        clk = 1'b0, rst = 1'b1, start = 1'b0, valid = 1'b0, wt = 1'b0;
   logic [15:0] index = '0;
   logic [23:0] len = '0;
   logic [7:0]  sd8 = '0, data8;
   logic [15:0] sd16 = '0, data16, idx8, idx16;
   logic [26:0] addr8, addr16;
   logic        busy8, done8, rdy8, dl8, wr8, busy16, done16, rdy16, dl16, wr16;

   int   checks = 0, errs = 0, cyc = 0;
   int   n_wr8 = 0, n_wr16 = 0, n_done8 = 0, n_done16 = 0, done_exp8 = 0, done_exp16 = 0, done_cyc8 = 0;
   logic prev_wr8 = 1'b0, prev_wr16 = 1'b0;
   wr_t  q8[$], q16[$], e8, e16;
   logic [7:0]  s8[$];
   logic [15:0] s16[$];
   int   wr_cyc8[$];

   ioctl_stream_gen #(.DATA_W(8), .ADDR_W(27), .LEN_W(24), .INTERVAL(6), .PRE_GAP(4), .POST_GAP(4)) u8 (
      .i_HPSIO_CLK(clk), .i_RST(rst), .i_START(start), .i_INDEX(index), .i_LEN(len),
      .o_BUSY(busy8), .o_DONE(done8), .i_SRC_DATA(sd8), .i_SRC_VALID(valid), .o_SRC_READY(rdy8),
      .o_IOCTL_DOWNLOAD(dl8), .o_IOCTL_INDEX(idx8), .o_IOCTL_ADDR(addr8), .o_IOCTL_DATA(data8),
      .o_IOCTL_WR(wr8), .i_IOCTL_WAIT(wt));

   ioctl_stream_gen #(.DATA_W(16), .ADDR_W(27), .LEN_W(24), .INTERVAL(6), .PRE_GAP(4), .POST_GAP(4)) u16 (
      .i_HPSIO_CLK(clk), .i_RST(rst), .i_START(start), .i_INDEX(index), .i_LEN(len),
      .o_BUSY(busy16), .o_DONE(done16), .i_SRC_DATA(sd16), .i_SRC_VALID(valid), .o_SRC_READY(rdy16),
      .o_IOCTL_DOWNLOAD(dl16), .o_IOCTL_INDEX(idx16), .o_IOCTL_ADDR(addr16), .o_IOCTL_DATA(data16),
      .o_IOCTL_WR(wr16), .i_IOCTL_WAIT(wt));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Source model: consume on handshake, present the queue head after the falling edge.
   always @(posedge clk) begin
      if (valid && rdy8 && s8.size() != 0) void'(s8.pop_front());
      if (valid && rdy16 && s16.size() != 0) void'(s16.pop_front());
   end
   always @(negedge clk) begin
      sd8  = (s8.size() != 0) ? s8[0] : 8'h00;
      sd16 = (s16.size() != 0) ? s16[0] : 16'h0000;
   end

   always @(negedge clk) begin
      if (wr8) begin
         n_wr8++;
         wr_cyc8.push_back(cyc);
         chk("wr8_width", prev_wr8, 0);
         chk("wr8_expected", q8.size() != 0, 1);
         if (q8.size() != 0) begin
            e8 = q8.pop_front();
            chk("wr8_addr", addr8, e8.a);
            chk("wr8_data", data8, e8.d);
            chk("wr8_index", idx8, e8.i);
         end
      end
      prev_wr8 = wr8;
      if (done8) begin
         n_done8++;
         done_cyc8 = cyc;
         chk("done8_expected", done_exp8 > 0, 1);
         if (done_exp8 > 0) done_exp8--;
         chk("done8_dl_busy", {dl8, busy8}, 0);
      end
   end

   always @(negedge clk) begin
      if (wr16) begin
         n_wr16++;
         chk("wr16_width", prev_wr16, 0);
         chk("wr16_expected", q16.size() != 0, 1);
         if (q16.size() != 0) begin
            e16 = q16.pop_front();
            chk("wr16_addr", addr16, e16.a);
            chk("wr16_data", data16, e16.d);
            chk("wr16_index", idx16, e16.i);
         end
      end
      prev_wr16 = wr16;
      if (done16) begin
         n_done16++;
         chk("done16_expected", done_exp16 > 0, 1);
         if (done_exp16 > 0) done_exp16--;
         chk("done16_dl_busy", {dl16, busy16}, 0);
      end
   end

   task automatic add_word(input int k, input logic [7:0] b, input logic [15:0] w, input logic [15:0] idx);
      wr_t e;
      e.a = 27'(k);
      e.d = {8'h00, b};
      e.i = idx;
      q8.push_back(e);
      e.a = 27'(2 * k);
      e.d = w;
      q16.push_back(e);
      s8.push_back(b);
      s16.push_back(w);
   endtask

   task automatic start_seg(input logic [15:0] idx, input logic [23:0] ln, output int t);
      @(negedge clk);
      t = cyc;
      start = 1'b1;
      index = idx;
      len = ln;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_wr(input int target);
      for (int i = 0; i < 300 && n_wr8 < target; i++) begin
         @(negedge clk);
         #1;
      end
      chk("wait_wr_timeout", n_wr8 >= target, 1);
   endtask

   task automatic wait_done(input int target);
      for (int i = 0; i < 300 && n_done8 < target; i++) begin
         @(negedge clk);
         #1;
      end
      chk("wait_done_timeout", n_done8 >= target, 1);
   endtask

   initial begin
      int t0, t1;
      repeat (3) @(negedge clk);
      chk("reset8", {busy8, done8, rdy8, dl8, wr8, idx8, addr8, data8}, 0);
      chk("reset16", {busy16, done16, rdy16, dl16, wr16, idx16, addr16, data16}, 0);
      rst = 1'b0;
      valid = 1'b1;

      // 1: three-word segment, nominal pacing
      add_word(0, 8'hAA, 16'hAA11, 16'd0);
      add_word(1, 8'hBB, 16'hBB22, 16'd0);
      add_word(2, 8'hCC, 16'hCC33, 16'd0);
      done_exp8 = 1; done_exp16 = 1;
      wr_cyc8.delete();
      start_seg(16'd0, 24'd3, t0);
      wait_done(1);
      chk("t1_wr_count", n_wr8, 3);
      chk("t1_first_wr", wr_cyc8[0] - t0, 7);
      chk("t1_gap01", wr_cyc8[1] - wr_cyc8[0], 7);
      chk("t1_gap12", wr_cyc8[2] - wr_cyc8[1], 7);
      chk("t1_addr8", addr8, 3);
      chk("t1_addr16", addr16, 6);

      // 2: index 254, 16-bit words
      add_word(0, 8'h12, 16'h1234, 16'd254);
      add_word(1, 8'h56, 16'h5678, 16'd254);
      done_exp8 = 1; done_exp16 = 1;
      start_seg(16'd254, 24'd2, t0);
      wait_done(2);
      chk("t2_wr_count16", n_wr16, 5);
      chk("t2_index16", idx16, 254);
      chk("t2_addr16", addr16, 4);

      // 3: WAIT for 10 cycles while WR is high
      add_word(0, 8'h31, 16'h3131, 16'd3);
      add_word(1, 8'h32, 16'h3232, 16'd3);
      done_exp8 = 1; done_exp16 = 1;
      wr_cyc8.delete();
      start_seg(16'd3, 24'd2, t0);
      wait_wr(6);
      wt = 1'b1;
      repeat (10) @(negedge clk);
      wt = 1'b0;
      wait_done(3);
      chk("t3_wr_count", n_wr8, 7);
      chk("t3_gap", wr_cyc8[1] - wr_cyc8[0], 17);

      // 4: source starves before the second word
      add_word(0, 8'h41, 16'h4141, 16'd4);
      add_word(1, 8'h42, 16'h4242, 16'd4);
      add_word(2, 8'h43, 16'h4343, 16'd4);
      done_exp8 = 1; done_exp16 = 1;
      start_seg(16'd4, 24'd3, t0);
      wait_wr(8);
      valid = 1'b0;
      repeat (20) @(negedge clk);
      #1;
      chk("t4_starve_wr", n_wr8, 8);
      chk("t4_starve_ready_dl", {rdy8, dl8, rdy16, dl16}, 4'hF);
      valid = 1'b1;
      wait_done(4);
      chk("t4_wr_count", n_wr8, 10);

      // 5: empty segment, second start while busy is ignored
      done_exp8 = 1; done_exp16 = 1;
      start_seg(16'd5, 24'd0, t0);
      repeat (2) @(negedge clk);
      start_seg(16'd77, 24'd2, t1);
      #1;
      chk("t5_index_kept", {idx8, idx16}, {16'd5, 16'd5});
      wait_done(5);
      chk("t5_done_time", done_cyc8 - t0, 9);
      repeat (20) @(negedge clk);
      chk("t5_no_extra", {n_wr8, n_done8, n_done16}, {32'd10, 32'd5, 32'd5});
      chk("t5_idle", {busy8, busy16, dl8, dl16}, 0);

      // 6: asynchronous reset inside a slot
      add_word(0, 8'h61, 16'h6161, 16'd6);
      start_seg(16'd6, 24'd3, t0);
      wait_wr(11);
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst8", {busy8, done8, rdy8, dl8, wr8, idx8, addr8, data8}, 0);
      chk("t6_rst16", {busy16, done16, rdy16, dl16, wr16, idx16, addr16, data16}, 0);
      @(negedge clk);
      rst = 1'b0;
      s8.delete();
      s16.delete();
      repeat (10) @(negedge clk);
      chk("t6_no_done", {n_done8, n_done16}, {32'd5, 32'd5});
      add_word(0, 8'h71, 16'h7171, 16'd7);
      done_exp8 = 1; done_exp16 = 1;
      start_seg(16'd7, 24'd1, t0);
      wait_done(6);
      chk("t6_addr", {addr8, addr16}, {27'd1, 27'd2});
      chk("t6_wr_count", {n_wr8, n_wr16}, {32'd12, 32'd12});

      repeat (5) @(negedge clk);
      chk("end_queues", {q8.size(), q16.size()}, 0);
      chk("end_done_pending", {done_exp8, done_exp16}, 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/ioctl_stream_gen.md
# ioctl_stream_gen

Synthesizable, parametrised generator for the HPS ioctl download bus. It plays one download segment per start command: it takes words from a valid/ready source and emits the MiSTer-style `download`/`index`/`addr`/`data`/`wr` sequence, with programmable pre/post gaps and write pacing. It generalises the fixed byte-wide ROM/DIP-switch ioctl stimulus to 8- or 16-bit data, arbitrary segment index and length, and source back-pressure. It sits between a segment source (bench file reader, DIP-switch packer, or on-chip ROM) and the core's ioctl loader.

## Interface
Parameters:
- `DATA_W`, 8: ioctl data width; only 8 or 16 are legal. Address step = `DATA_W/8`.
- `ADDR_W`, 27: width of `o_IOCTL_ADDR`.
- `LEN_W`, 24: width of the segment length, counted in words.
- `INTERVAL`, 6: cycles per write slot; minimum 3.
- `PRE_GAP`, 192: non-wait cycles after `download` rises, before the first fetch.
- `POST_GAP`, 128: non-wait cycles after `download` falls, before `o_DONE`.

Ports:
- `i_HPSIO_CLK` in 1: the single clock.
- `i_RST` in 1: asynchronous, active-high reset.
- `i_START` in 1: one-cycle segment start request.
- `i_INDEX` in 16: segment ioctl index, sampled with `i_START`.
- `i_LEN` in `LEN_W`: segment length in words, sampled with `i_START`.
- `o_BUSY` out 1: a segment is in progress.
- `o_DONE` out 1: one-cycle pulse when a segment ends.
- `i_SRC_DATA` in `DATA_W`: source word.
- `i_SRC_VALID` in 1: source word valid.
- `o_SRC_READY` out 1: word accepted when both `i_SRC_VALID` and `o_SRC_READY` are high.
- `o_IOCTL_DOWNLOAD` out 1: ioctl download active.
- `o_IOCTL_INDEX` out 16: ioctl index.
- `o_IOCTL_ADDR` out `ADDR_W`: ioctl address.
- `o_IOCTL_DATA` out `DATA_W`: ioctl data.
- `o_IOCTL_WR` out 1: ioctl write strobe.
- `i_IOCTL_WAIT` in 1: core back-pressure.

## Operation
States: IDLE, PRE, FETCH, SLOT, POST.

- **Reset values.** `i_RST` high forces every output to 0 immediately (asynchronous), including `o_IOCTL_ADDR` and `o_IOCTL_INDEX`. State goes to IDLE and all counters clear. Reset mid-segment abandons the segment and produces no `o_DONE`.
- **IDLE.** `i_START` is sampled here only; when not in IDLE it is ignored.
  - On a sampled start: latch `i_INDEX` into `o_IOCTL_INDEX`, latch `i_LEN` into the remaining-word counter, clear `o_IOCTL_ADDR`, set `o_BUSY` and `o_IOCTL_DOWNLOAD`, go to PRE.
- **PRE.** The gap counter advances only on cycles with `i_IOCTL_WAIT`=0.
  - After `PRE_GAP` counted cycles: go to FETCH if length ≠ 0, otherwise go to POST.
- **FETCH.** `o_SRC_READY` = (state==FETCH) & ~`i_IOCTL_WAIT`, combinational.
  - On handshake: register `i_SRC_DATA` into `o_IOCTL_DATA`, clear the slot counter `c`, go to SLOT.
  - Source starvation holds FETCH indefinitely: no timeout, `download` stays high.
- **SLOT.** `c` runs 0..`INTERVAL`-1 and advances only when `i_IOCTL_WAIT`=0.
  - The edge advancing `c` from 0 to 1 sets `o_IOCTL_WR`. The next edge clears it unconditionally, so the strobe is exactly one cycle and is never stretched by WAIT.
  - On the edge leaving `c`=`INTERVAL`-1: add `DATA_W/8` to `o_IOCTL_ADDR`, modulo 2^`ADDR_W`, and decrement the remaining count. If the count reaches 0, go to POST; otherwise go to FETCH.
  - `o_IOCTL_ADDR` and `o_IOCTL_DATA` are stable from capture until the end of the slot. Word k is written at address k·`DATA_W/8`.
- **POST.** `o_IOCTL_DOWNLOAD` clears on entry; the gap counter is WAIT-frozen as in PRE.
  - After `POST_GAP` counted cycles: pulse `o_DONE`, clear `o_BUSY`, return to IDLE.
  - `o_IOCTL_INDEX`, `o_IOCTL_ADDR` and `o_IOCTL_DATA` hold their last values until the next start or reset.
- **Width rule.** The 16-bit mode uses the full data word, and addresses step by 2 (byte addressing).

## Timing
- All outputs are registered except `o_SRC_READY`.
- Start to `download`=1: 1 cycle.
- With WAIT=0 and a source that is always valid: the first WR occurs `PRE_GAP`+3 cycles after the start edge. Successive WR pulses are `INTERVAL`+1 cycles apart.
- Each WAIT cycle in PRE, SLOT or POST delays everything downstream by exactly one cycle. In FETCH, WAIT blocks the handshake.
- `o_DONE` fires `POST_GAP` counted cycles after `download` falls. `o_BUSY` falls on the same edge as `o_DONE` rises.

## Test plan
1. **8-bit segment.** `DATA_W`=8, `PRE_GAP`=4, `INTERVAL`=6, `POST_GAP`=4; start with index 0, len 3, data AA, BB, CC always valid.
   - Expect WR exactly 3 times, with addr/data 0/AA, 1/BB, 2/CC, pulses 7 cycles apart.
   - Expect final addr 3, one `o_DONE`, and `download` low before DONE.
2. **16-bit segment.** `DATA_W`=16; start with index 254, len 2, data 1234, 5678.
   - Expect WR at addr 0 with 1234 and addr 2 with 5678, and `o_IOCTL_INDEX`=254 throughout.
3. **WAIT mid-slot.** Raise `i_IOCTL_WAIT` for 10 cycles with `c`=1, while WR is high.
   - Expect WR high for exactly 1 cycle, the next WR 10 cycles later than nominal, and no extra or missing writes.
4. **Source starvation.** Hold `i_SRC_VALID` low for 20 cycles before word 2.
   - Expect state to stay in FETCH with `o_SRC_READY`=1, no WR, and `download`=1.
   - When valid returns, expect the word written at addr 1.
5. **Empty segment and ignored start.** Start with len 0.
   - Expect zero WR pulses and `o_DONE` after PRE+POST.
   - A second `i_START` during busy must be ignored: no index change, a single DONE.
6. **Asynchronous reset mid-slot.** Assert `i_RST` in SLOT, off the clock edge.
   - Expect all outputs 0 immediately and no DONE.
   - After release, a new start with len 1 must complete normally at addr 0.
